// File: rtl/div_ctrl_pkg.sv
// Shared constants and state type for the execute-stage divide sequencer.
package div_ctrl_pkg;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [4:0] DIV_CONTROL  = 5'b10110;
  localparam logic [4:0] DIVU_CONTROL = 5'b10111;

  localparam logic [31:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    DCTRL_IDLE  = 2'b00,
    DCTRL_BUSY  = 2'b01,
    DCTRL_DONE  = 2'b10,
    DCTRL_ABORT = 2'b11
  } dctrl_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// EX-side request/result and divider-side handshake bundle for div_ctrl.
interface div_ctrl_if;
  logic        div_req_i;
  logic [4:0]  alucontrol_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        flush_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic [4:0]  div_alucontrol_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        stall_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport slave (
    input  div_req_i, alucontrol_i, op1_i, op2_i, flush_i, div_result_i, div_ready_i,
    output div_start_o, div_annul_o, div_alucontrol_o, div_op1_o, div_op2_o,
    output stall_o, hilo_we_o, hi_o, lo_o
  );

  modport master (
    output div_req_i, alucontrol_i, op1_i, op2_i, flush_i, div_result_i, div_ready_i,
    input  div_start_o, div_annul_o, div_alucontrol_o, div_op1_o, div_op2_o,
    input  stall_o, hilo_we_o, hi_o, lo_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Sequences one DIV/DIVU through the multicycle divider: latch, run, write HI/LO
// once, or annul cleanly when EX is flushed.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned ABORT_CYC = 2
) (
  input  logic     clk,
  input  logic     rst,
  div_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(ABORT_CYC + 1);

  dctrl_state_e     r_state;
  dctrl_state_e     w_next;
  logic [CNT_W-1:0] r_abort_cnt;
  logic             r_start;
  logic             r_annul;
  logic             r_we;
  logic [4:0]       r_ctl;
  logic [31:0]      r_op1;
  logic [31:0]      r_op2;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             w_accept;

  assign w_accept = bus.div_req_i & ~bus.flush_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      DCTRL_IDLE:  if (w_accept) w_next = DCTRL_BUSY;
      DCTRL_BUSY: begin
        if (bus.flush_i)                          w_next = DCTRL_ABORT;
        else if (bus.div_ready_i == DivResultReady) w_next = DCTRL_DONE;
      end
      DCTRL_DONE:  w_next = DCTRL_IDLE;
      DCTRL_ABORT: if (r_abort_cnt == '0) w_next = DCTRL_IDLE;
      default:     w_next = DCTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= DCTRL_IDLE;
    else      r_state <= w_next;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start     <= DivStop;
      r_annul     <= 1'b0;
      r_we        <= 1'b0;
      r_ctl       <= '0;
      r_op1       <= ZeroWord;
      r_op2       <= ZeroWord;
      r_hi        <= ZeroWord;
      r_lo        <= ZeroWord;
      r_abort_cnt <= '0;
    end else begin
      r_start <= (w_next == DCTRL_BUSY) ? DivStart : DivStop;
      r_annul <= (w_next == DCTRL_ABORT);
      r_we    <= (w_next == DCTRL_DONE);
      if (r_state == DCTRL_IDLE && w_accept) begin
        r_ctl <= bus.alucontrol_i;
        r_op1 <= bus.op1_i;
        r_op2 <= bus.op2_i;
      end
      if (r_state == DCTRL_BUSY && w_next == DCTRL_DONE) begin
        r_hi <= bus.div_result_i[63:32];
        r_lo <= bus.div_result_i[31:0];
      end
      if (r_state == DCTRL_BUSY && w_next == DCTRL_ABORT)
        r_abort_cnt <= CNT_W'(ABORT_CYC - 1);
      else if (r_state == DCTRL_ABORT && r_abort_cnt != '0)
        r_abort_cnt <= r_abort_cnt - CNT_W'(1);
    end
  end

  assign bus.div_start_o      = r_start;
  assign bus.div_annul_o      = r_annul;
  assign bus.div_alucontrol_o = r_ctl;
  assign bus.div_op1_o        = r_op1;
  assign bus.div_op2_o        = r_op2;
  assign bus.hi_o             = r_hi;
  assign bus.lo_o             = r_lo;
  // Strobe is registered on DONE entry but still dropped by a flush arriving in DONE itself.
  assign bus.hilo_we_o        = r_we & ~bus.flush_i;
  assign bus.stall_o          = ((r_state == DCTRL_IDLE) & w_accept)
                              | (r_state == DCTRL_BUSY)
                              | ((r_state == DCTRL_ABORT) & bus.div_req_i);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural 36-cycle divider standing in for div.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_ctrl_if bus();

  div_ctrl #(.ABORT_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Divider stand-in: ready on the 36th consecutive start cycle, result {rem, quo}.
  logic [5:0] m_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst)                                     m_cnt <= '0;
    else if (!bus.div_start_o || bus.div_annul_o) m_cnt <= '0;
    else if (m_cnt != 6'd35)                      m_cnt <= m_cnt + 6'd1;
  end
  assign bus.div_ready_i = bus.div_start_o && !bus.div_annul_o && (m_cnt == 6'd35);

  logic signed [31:0] m_sa, m_sb;
  assign m_sa = bus.div_op1_o;
  assign m_sb = bus.div_op2_o;
  always_comb begin
    bus.div_result_i = '0;
    if (bus.div_op2_o != 32'd0) begin
      if (bus.div_alucontrol_o == DIV_CONTROL)
        bus.div_result_i = {m_sa % m_sb, m_sa / m_sb};
      else
        bus.div_result_i = {bus.div_op1_o % bus.div_op2_o, bus.div_op1_o / bus.div_op2_o};
    end
  end

  task automatic run_div(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int we_cnt, output int annul_n,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic ctl_ok, output logic start0);
    bus.alucontrol_i = ctl;
    bus.op1_i        = a;
    bus.op2_i        = b;
    bus.div_req_i    = 1'b1;
    lat = 0; we_cnt = 0; annul_n = 0; ctl_ok = 1'b1;
    #1;
    start0 = bus.div_start_o;
    while (lat < 100) begin
      if (bus.hilo_we_o) we_cnt++;
      if (bus.div_annul_o) annul_n++;
      if (bus.div_start_o && bus.div_alucontrol_o !== ctl) ctl_ok = 1'b0;
      if (!bus.stall_o) break;
      @(posedge clk); #2;
      lat++;
    end
    hi = bus.hi_o;
    lo = bus.lo_o;
    if (bus.div_alucontrol_o !== ctl) ctl_ok = 1'b0;
    @(posedge clk); #1;
    bus.div_req_i = 1'b0;
    #1;
    if (bus.hilo_we_o) we_cnt++;
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    checks++; if (bus.div_start_o !== DivStop) begin errors++; $display("FAIL reset_start got %0h want 0", bus.div_start_o); end
    checks++; if (bus.div_annul_o !== 1'b0) begin errors++; $display("FAIL reset_annul got %0h want 0", bus.div_annul_o); end
    checks++; if (bus.hilo_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %0h want 0", bus.hilo_we_o); end
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %0h want 0", {bus.hi_o, bus.lo_o}); end
    checks++; if ({bus.div_alucontrol_o, bus.div_op1_o, bus.div_op2_o} !== 69'd0) begin errors++; $display("FAIL reset_ops got %0h want 0", {bus.div_alucontrol_o, bus.div_op1_o, bus.div_op2_o}); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h want 0", bus.stall_o); end
  endtask

  task automatic test_divu_basic();
    int lat, we, an; logic [31:0] hi, lo; logic ok, s0;
    run_div(DIVU_CONTROL, 32'd100, 32'd7, lat, we, an, hi, lo, ok, s0);
    checks++; if (lat !== 37) begin errors++; $display("FAIL divu100_latency got %0d want 37", lat); end
    checks++; if (we !== 1) begin errors++; $display("FAIL divu100_we_pulses got %0d want 1", we); end
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu100_hilo got %0h want 2,e", {hi, lo}); end
    checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL divu100_start_idle got %0h want 0", s0); end
  endtask

  task automatic test_signed();
    int lat, we, an; logic [31:0] hi, lo; logic ok, s0;
    run_div(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, lat, we, an, hi, lo, ok, s0);
    checks++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_m7_2 got %0h want ffffffff_fffffffd", {hi, lo}); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL div_m7_2_ctl_stable got %0h want 1", ok); end
    run_div(DIV_CONTROL, 32'd7, 32'hFFFF_FFFE, lat, we, an, hi, lo, ok, s0);
    checks++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_7_m2 got %0h want 1_fffffffd", {hi, lo}); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL div_7_m2_ctl_stable got %0h want 1", ok); end
  endtask

  task automatic test_div_zero();
    int lat, we, an; logic [31:0] hi, lo; logic ok, s0;
    run_div(DIVU_CONTROL, 32'd5, 32'd0, lat, we, an, hi, lo, ok, s0);
    checks++; if (we !== 1) begin errors++; $display("FAIL divzero_we got %0d want 1", we); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL divzero_hilo got %0h want 0", {hi, lo}); end
    run_div(DIVU_CONTROL, 32'd9, 32'd3, lat, we, an, hi, lo, ok, s0);
    checks++; if ({hi, lo} !== {32'd0, 32'd3}) begin errors++; $display("FAIL divu9_3 got %0h want 0,3", {hi, lo}); end
  endtask

  task automatic test_flush_busy();
    int lat, we, an, busy, n; logic [31:0] hi, lo; logic ok, s0;
    bus.alucontrol_i = DIVU_CONTROL; bus.op1_i = 32'd50; bus.op2_i = 32'd7; bus.div_req_i = 1'b1;
    busy = 0; n = 0;
    while (busy < 10 && n < 60) begin
      @(posedge clk); #2; n++;
      if (bus.div_start_o) busy++;
    end
    checks++; if (busy !== 10) begin errors++; $display("FAIL flush_busy_reach got %0d want 10", busy); end
    bus.flush_i = 1'b1; bus.div_req_i = 1'b0;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    #1;
    checks++; if ({bus.div_annul_o, bus.div_start_o, bus.hilo_we_o} !== 3'b100) begin errors++; $display("FAIL flush_busy_abort got %0b want 100", {bus.div_annul_o, bus.div_start_o, bus.hilo_we_o}); end
    checks++; if ({bus.hi_o, bus.lo_o} !== {32'd0, 32'd3}) begin errors++; $display("FAIL flush_busy_hilo_hold got %0h want 0,3", {bus.hi_o, bus.lo_o}); end
    run_div(DIVU_CONTROL, 32'd20, 32'd6, lat, we, an, hi, lo, ok, s0);
    checks++; if (an !== 2) begin errors++; $display("FAIL flush_busy_annul_cycles got %0d want 2", an); end
    checks++; if (lat !== 39) begin errors++; $display("FAIL abort_req_latency got %0d want 39", lat); end
    checks++; if (we !== 1) begin errors++; $display("FAIL abort_req_we got %0d want 1", we); end
    checks++; if ({hi, lo} !== {32'd2, 32'd3}) begin errors++; $display("FAIL divu20_6 got %0h want 2,3", {hi, lo}); end
  endtask

  task automatic test_flush_ready();
    int n, we;
    bus.alucontrol_i = DIVU_CONTROL; bus.op1_i = 32'd30; bus.op2_i = 32'd4; bus.div_req_i = 1'b1;
    n = 0;
    while (!bus.div_ready_i && n < 60) begin @(posedge clk); #2; n++; end
    checks++; if (n !== 36) begin errors++; $display("FAIL flush_ready_seen got %0d want 36", n); end
    bus.flush_i = 1'b1; bus.div_req_i = 1'b0;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    #1;
    checks++; if ({bus.div_annul_o, bus.hilo_we_o} !== 2'b10) begin errors++; $display("FAIL flush_ready_abort got %0b want 10", {bus.div_annul_o, bus.hilo_we_o}); end
    we = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      if (bus.hilo_we_o) we++;
    end
    checks++; if (we !== 0) begin errors++; $display("FAIL flush_ready_no_write got %0d want 0", we); end
    checks++; if ({bus.hi_o, bus.lo_o, bus.div_annul_o} !== {32'd2, 32'd3, 1'b0}) begin errors++; $display("FAIL flush_ready_hold got %0h want 2,3,0", {bus.hi_o, bus.lo_o, bus.div_annul_o}); end
  endtask

  task automatic test_flush_done();
    int n;
    bus.alucontrol_i = DIVU_CONTROL; bus.op1_i = 32'd30; bus.op2_i = 32'd4; bus.div_req_i = 1'b1;
    #1;
    n = 0;
    while (bus.stall_o && n < 60) begin @(posedge clk); #2; n++; end
    checks++; if (n !== 37) begin errors++; $display("FAIL flush_done_reach got %0d want 37", n); end
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.hilo_we_o !== 1'b0) begin errors++; $display("FAIL flush_done_we got %0h want 0", bus.hilo_we_o); end
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.div_req_i = 1'b0;
    #1;
    checks++; if ({bus.hilo_we_o, bus.stall_o} !== 2'b00) begin errors++; $display("FAIL flush_done_after got %0b want 00", {bus.hilo_we_o, bus.stall_o}); end
  endtask

  task automatic test_back_to_back();
    int lat, we, an; logic [31:0] hi, lo; logic ok, s0;
    run_div(DIVU_CONTROL, 32'd10, 32'd3, lat, we, an, hi, lo, ok, s0);
    checks++; if ({hi, lo} !== {32'd1, 32'd3} || we !== 1) begin errors++; $display("FAIL b2b_first got %0h we %0d want 1,3 we 1", {hi, lo}, we); end
    run_div(DIVU_CONTROL, 32'd11, 32'd4, lat, we, an, hi, lo, ok, s0);
    checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL b2b_dead_cycle got %0h want 0", s0); end
    checks++; if (lat !== 37) begin errors++; $display("FAIL b2b_latency got %0d want 37", lat); end
    checks++; if ({hi, lo} !== {32'd3, 32'd2} || we !== 1) begin errors++; $display("FAIL b2b_second got %0h we %0d want 3,2 we 1", {hi, lo}, we); end
  endtask

  task automatic test_reset_mid();
    int lat, we, an; logic [31:0] hi, lo; logic ok, s0;
    bus.alucontrol_i = DIVU_CONTROL; bus.op1_i = 32'd100; bus.op2_i = 32'd7; bus.div_req_i = 1'b1;
    repeat (5) begin @(posedge clk); #2; end
    checks++; if (bus.div_start_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %0h want 1", bus.div_start_o); end
    bus.div_req_i = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if ({bus.div_start_o, bus.div_annul_o, bus.hilo_we_o, bus.stall_o} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctrl got %0b want 0000", {bus.div_start_o, bus.div_annul_o, bus.hilo_we_o, bus.stall_o}); end
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo got %0h want 0", {bus.hi_o, bus.lo_o}); end
    checks++; if ({bus.div_alucontrol_o, bus.div_op1_o, bus.div_op2_o} !== 69'd0) begin errors++; $display("FAIL rstmid_ops got %0h want 0", {bus.div_alucontrol_o, bus.div_op1_o, bus.div_op2_o}); end
    @(posedge clk); #1;
    rst = 1'b1;
    run_div(DIVU_CONTROL, 32'd8, 32'd2, lat, we, an, hi, lo, ok, s0);
    checks++; if ({hi, lo} !== {32'd0, 32'd4} || we !== 1) begin errors++; $display("FAIL rstmid_divu8_2 got %0h we %0d want 0,4 we 1", {hi, lo}, we); end
  endtask

  initial begin
    bus.div_req_i    = 1'b0;
    bus.alucontrol_i = '0;
    bus.op1_i        = '0;
    bus.op2_i        = '0;
    bus.flush_i      = 1'b0;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_flush_busy();
    test_flush_ready();
    test_flush_done();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
